joy_conditioner: RTL
====================

// Module: joy_conditioner
// PURPOSE
//   Conditions the five raw joystick inputs before they reach the pong game core.
//   Each button is synchronised, debounced and edge-detected.
//   Outputs are a clean level vector and a one-cycle press-pulse vector.
//   Sits between the board pins and vgaPong; all outputs are registered in the clk domain.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  consecutive stable cycles required to accept a new level (10 ms @ 50 MHz); min 1
//   REPEAT_DELAY     25000000  cycles held before the first auto-repeat pulse (JOY_REPEAT_EN only); min 1
//   REPEAT_RATE      5000000   cycles between subsequent auto-repeat pulses (JOY_REPEAT_EN only); min 1
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous reset, active-high
//   joy_right   in   1  raw, asynchronous, active-high
//   joy_left    in   1  raw, asynchronous, active-high
//   joy_up      in   1  raw, asynchronous, active-high
//   joy_down    in   1  raw, asynchronous, active-high
//   joy_select  in   1  raw, asynchronous, active-high
//   joy_state   out  5  debounced level; bit order {select,down,up,left,right} = [4:0]
//   joy_press   out  5  one-cycle pulse per accepted 0->1 transition (plus repeats, see CONFIGURATION)
// BEHAVIOUR
//   - Reset: sync flops, counters, joy_state and joy_press all 0. Reset wins over every other event.
//     Reset asserted mid-count discards the count; buttons still held after reset are re-accepted
//     after a full debounce period.
//   - Per bit: two-flop synchroniser (s1->s2), then a counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
//     - s2 == joy_state: cnt <= 0.
//     - s2 != joy_state and cnt == DEBOUNCE_CYCLES-1: joy_state <= s2, cnt <= 0.
//     - otherwise: cnt <= cnt+1.
//   - Latency: a clean raw level change sampled first at edge N updates joy_state at edge N+DEBOUNCE_CYCLES+2.
//   - Glitch rejection: any return to the old level before the count completes clears cnt.
//     No output change, no pulse.
//   - joy_press[i] is 1 for exactly the cycle in which joy_state[i] goes 0->1. A 1->0 transition produces no pulse.
//   - Channels are fully independent. Simultaneous presses pulse in the same cycle.
//     Opposing directions (up+down, left+right) are passed through unresolved; the game core arbitrates.
//   - The counter never wraps: it is bounded by DEBOUNCE_CYCLES-1.
// CONFIGURATION
//   JOY_REPEAT_EN defined:
//     - Bits [3:0] (directions) get a per-bit repeat counter rcnt, cleared whenever joy_state[i]==0 or on the press cycle.
//     - While held, an extra one-cycle joy_press[i] pulse fires REPEAT_DELAY cycles after the press pulse,
//       then every REPEAT_RATE cycles.
//     - Release stops repeats immediately.
//     - Select (bit 4) never repeats.
//   JOY_REPEAT_EN undefined: exactly one pulse per accepted press; no repeat counters synthesised.
// STRUCTURE
//   - Package joy_pkg: NUM_BTN=5; index constants BTN_RIGHT=0, BTN_LEFT=1, BTN_UP=2, BTN_DOWN=3, BTN_SELECT=4.
//     Shared with vgaPong.
//   - Sub-module debounce_bit: synchroniser, debounce counter, level register and edge pulse for one
//     channel, with DEBOUNCE_CYCLES as its parameter.
//   - joy_conditioner instantiates 5 via generate, and adds the optional repeat logic per direction bit.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3)
//   1. rst high 3 cycles with all inputs high -> joy_state=0, joy_press=0 throughout reset;
//      after release, joy_state=5'h1F exactly 6 cycles later, joy_press=5'h1F for one cycle.
//   2. joy_up 0->1, held 20 cycles -> joy_state[2] rises 6 cycles after the first sampling edge;
//      one joy_press[2] pulse without JOY_REPEAT_EN.
//   3. joy_left toggles every 2 cycles for 16 cycles, then 0 -> joy_state[1] and joy_press[1] stay 0.
//   4. joy_down held then released -> joy_state[3] falls 6 cycles after release; no pulse on the falling transition.
//   5. joy_right and joy_select asserted on the same edge -> joy_press=5'h11 for one cycle, in the same cycle.
//   6. With JOY_REPEAT_EN, joy_up held 30 cycles after acceptance (press pulse at cycle T) ->
//      pulses at T, T+8, T+11, T+14...; none after release.
//      Same stimulus on joy_select -> single pulse at T.
//      rst pulsed at cnt=2 -> no acceptance until 4 stable cycles after reset.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared joystick definitions: button count and bit positions in the
// five-bit button vectors. Also used by the game core.
package joy_pkg;

  localparam int NUM_BTN    = 5;
  localparam int NUM_DIR    = 4;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_SELECT = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/joy_if.sv
// Joystick bundle: five raw asynchronous pins toward the conditioner and
// the conditioned level/press vectors back out.
// master = board/pin side, slave = conditioner.
interface joy_if;
  import joy_pkg::*;

  logic     joy_right;
  logic     joy_left;
  logic     joy_up;
  logic     joy_down;
  logic     joy_select;
  btn_vec_t joy_state;
  btn_vec_t joy_press;

  modport master (
    output joy_right, joy_left, joy_up, joy_down, joy_select,
    input  joy_state, joy_press
  );

  modport slave (
    input  joy_right, joy_left, joy_up, joy_down, joy_select,
    output joy_state, joy_press
  );

endinterface

// File: rtl/debounce_bit.sv
// One button channel: two-flop synchroniser, debounce counter, accepted
// level register and a one-cycle rise pulse aligned with the level going
// high. The counter is bounded at DEBOUNCE_CYCLES-1 and never wraps.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        rise  <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joy_conditioner.sv
// Joystick conditioner: five debounced channels with registered level and
// press-pulse outputs. Define JOY_REPEAT_EN to add auto-repeat press pulses
// on the four direction bits while they are held; select never repeats.
// The outputs are one register stage behind the per-channel level/rise, so
// the repeat counters work from the internal level and land their pulses in
// the same output register as the primary press.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst,
  joy_if.slave joy
);

  btn_vec_t raw;
  btn_vec_t level;
  btn_vec_t rise;
  btn_vec_t rep_hit;
  btn_vec_t state_q;
  btn_vec_t press_q;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("joy_conditioner: timing parameters must be at least 1");
  end

  assign raw[BTN_RIGHT]  = joy.joy_right;
  assign raw[BTN_LEFT]   = joy.joy_left;
  assign raw[BTN_UP]     = joy.joy_up;
  assign raw[BTN_DOWN]   = joy.joy_down;
  assign raw[BTN_SELECT] = joy.joy_select;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

`ifdef JOY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_rep
    logic [RW-1:0] rcnt;

    // rcnt==1 means the next output cycle carries a repeat pulse.
    assign rep_hit[i] = level[i] & ~rise[i] & (rcnt == RW'(1));

    // Down-counter: loaded with the initial delay on press, reloaded with the rate on each repeat.
    always_ff @(posedge clk) begin
      if (rst || !level[i]) begin
        rcnt <= '0;
      end else if (rise[i]) begin
        rcnt <= RW'(REPEAT_DELAY);
      end else if (rcnt == RW'(1)) begin
        rcnt <= RW'(REPEAT_RATE);
      end else if (rcnt != '0) begin
        rcnt <= rcnt - 1'b1;
      end
    end
  end

  assign rep_hit[BTN_SELECT] = 1'b0;
`else
  assign rep_hit = '0;
`endif

  // Output register stage for the level and press vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      press_q <= '0;
    end else begin
      state_q <= level;
      press_q <= rise | rep_hit;
    end
  end

  assign joy.joy_state = state_q;
  assign joy.joy_press = press_q;

endmodule
